// File: rtl/bch_chase_ctrl.sv
// -----------------------------------------------------------------------------
// bch_chase_ctrl
//
// Chase-style candidate scheduler placed in front of bch_hard_core. It takes
// one hard-decision word and up to P_MAX least-reliable bit positions, builds
// 2^p test patterns by flipping subsets of those positions, and runs the core
// once per pattern. Among the candidates the core decodes successfully, it
// reports the one with the lowest total correction weight. The weight counts
// bits relative to the original hard word.
//
// Ports
//   clk, rst            : clock; synchronous active-high reset
//   start               : one-cycle request, honoured only in IDLE
//   n, t, m             : code length / capability / field degree (latched)
//   p                   : number of flip positions in use (latched)
//   hard_bits           : received hard word (latched)
//   lrp_idx             : flip position i in bits [10i+9:10i] (latched)
//   core_start          : one-cycle launch pulse to the core
//   core_n/t/m          : latched n, t, m forwarded to the core
//   core_bits           : candidate word = hard_bits ^ flip mask
//   core_done           : core completion pulse
//   core_success        : core success flag, qualified by core_done
//   core_err_vec        : core error vector, qualified by core_done
//   busy                : high in every state except IDLE
//   done                : one-cycle completion pulse
//   success             : at least one candidate decoded
//   err_vec             : best total correction relative to hard_bits
//   best_cand, best_wt  : winning candidate index and popcount(err_vec)
//   o_dbg_state         : current FSM state, for observation only
//
// Core handshake: core_start is a single-cycle pulse, and core_bits/n/t/m
// stay stable from that cycle until the core answers. The core answers with a
// single-cycle core_done pulse, and core_success/core_err_vec are valid in
// that same cycle. A core_done is accepted only while waiting for the current
// candidate. At any other time it is ignored.
// -----------------------------------------------------------------------------
module bch_chase_ctrl #(
    parameter int N_MAX   = 63,
    parameter int P_MAX   = 3,
    parameter int TMO_W   = 12,
    parameter int TMO_CYC = 4000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [9:0]            n,
    input  logic [3:0]            t,
    input  logic [3:0]            m,
    input  logic [1:0]            p,
    input  logic [N_MAX-1:0]      hard_bits,
    input  logic [10*P_MAX-1:0]   lrp_idx,
    output logic                  core_start,
    output logic [9:0]            core_n,
    output logic [3:0]            core_t,
    output logic [3:0]            core_m,
    output logic [N_MAX-1:0]      core_bits,
    input  logic                  core_done,
    input  logic                  core_success,
    input  logic [N_MAX-1:0]      core_err_vec,
    output logic                  busy,
    output logic                  done,
    output logic                  success,
    output logic [N_MAX-1:0]      err_vec,
    output logic [P_MAX-1:0]      best_cand,
    output logic [9:0]            best_wt,
    output logic [2:0]            o_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_WAIT   = 3'd2,
        S_EVAL   = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    state_t               r_state;
    logic [1:0]           r_p;
    logic [N_MAX-1:0]     r_hard;
    logic [10*P_MAX-1:0]  r_lrp;
    logic [P_MAX-1:0]     r_cand;
    logic [TMO_W-1:0]     r_tmo_cnt;
    logic                 r_best_valid;
    logic                 r_cand_ok;
    logic [N_MAX-1:0]     r_tot;
    logic                 r_core_start;
    logic [9:0]           r_core_n;
    logic [3:0]           r_core_t;
    logic [3:0]           r_core_m;
    logic [N_MAX-1:0]     r_core_bits;
    logic                 r_done;
    logic                 r_success;
    logic [N_MAX-1:0]     r_err_vec;
    logic [P_MAX-1:0]     r_best_cand;
    logic [9:0]           r_best_wt;

    logic [P_MAX-1:0]     w_last_cand;
    logic [P_MAX-1:0]     w_cand_next;
    logic [N_MAX-1:0]     w_mask_cur;
    logic [N_MAX-1:0]     w_mask_next;
    logic [9:0]           w_wt;
    logic                 w_upd;
    logic                 w_tmo_hit;

    // Flip mask for one candidate. Out-of-range positions are dropped, and
    // duplicate positions toggle the same bit twice, so they cancel.
    function automatic logic [N_MAX-1:0] f_mask(
        input logic [P_MAX-1:0]  cand,
        input logic [1:0]        pp,
        input logic [9:0]        nn,
        input logic [10*P_MAX-1:0] lrp
    );
        logic [N_MAX-1:0] mk;
        logic [9:0]       pos;
        mk = '0;
        for (int i = 0; i < P_MAX; i++) begin
            pos = lrp[10*i +: 10];
            if ((i < int'(pp)) && cand[i] && (pos < nn)) begin
                for (int j = 0; j < N_MAX; j++) begin
                    if (pos == 10'(j)) mk[j] = ~mk[j];
                end
            end
        end
        return mk;
    endfunction

    function automatic logic [9:0] f_popcount(input logic [N_MAX-1:0] v);
        logic [9:0] cnt;
        cnt = '0;
        for (int j = 0; j < N_MAX; j++) cnt = cnt + 10'(v[j]);
        return cnt;
    endfunction

    // The last candidate index is 2^p-1, which has the low p bits set.
    always_comb begin
        w_last_cand = '0;
        for (int i = 0; i < P_MAX; i++) begin
            if (i < int'(r_p)) w_last_cand[i] = 1'b1;
        end
    end

    assign w_cand_next = r_cand + {{(P_MAX-1){1'b0}}, 1'b1};
    assign w_mask_cur  = f_mask(r_cand, r_p, r_core_n, r_lrp);
    assign w_mask_next = f_mask(w_cand_next, r_p, r_core_n, r_lrp);
    assign w_wt        = f_popcount(r_tot);
    // A strict less-than keeps the earlier (lower-index) candidate on a tie.
    assign w_upd       = r_cand_ok && (!r_best_valid || (w_wt < r_best_wt));
    assign w_tmo_hit   = (r_tmo_cnt == TMO_W'(TMO_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_p          <= '0;
            r_hard       <= '0;
            r_lrp        <= '0;
            r_cand       <= '0;
            r_tmo_cnt    <= '0;
            r_best_valid <= 1'b0;
            r_cand_ok    <= 1'b0;
            r_tot        <= '0;
            r_core_start <= 1'b0;
            r_core_n     <= '0;
            r_core_t     <= '0;
            r_core_m     <= '0;
            r_core_bits  <= '0;
            r_done       <= 1'b0;
            r_success    <= 1'b0;
            r_err_vec    <= '0;
            r_best_cand  <= '0;
            r_best_wt    <= '0;
        end else begin
            r_core_start <= 1'b0;
            r_done       <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_core_n     <= n;
                        r_core_t     <= t;
                        r_core_m     <= m;
                        r_p          <= p;
                        r_hard       <= hard_bits;
                        r_lrp        <= lrp_idx;
                        r_cand       <= '0;
                        r_best_valid <= 1'b0;
                        // Candidate 0 never flips anything.
                        r_core_bits  <= hard_bits;
                        r_core_start <= 1'b1;
                        r_state      <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    r_tmo_cnt <= '0;
                    r_state   <= S_WAIT;
                end
                S_WAIT: begin
                    if (core_done) begin
                        r_cand_ok <= core_success;
                        // Fold the flips back in so the correction is
                        // relative to the original hard word.
                        r_tot     <= core_err_vec ^ w_mask_cur;
                        r_state   <= S_EVAL;
                    end else if (w_tmo_hit) begin
                        r_cand_ok <= 1'b0;
                        r_tot     <= '0;
                        r_state   <= S_EVAL;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
                end
                S_EVAL: begin
                    if (w_upd) begin
                        r_err_vec    <= r_tot;
                        r_best_wt    <= w_wt;
                        r_best_cand  <= r_cand;
                        r_best_valid <= 1'b1;
                    end
                    if (r_cand == w_last_cand) begin
                        // done and success are driven during the FINISH
                        // cycle. Any result left over from an earlier run is
                        // cleared when no candidate in this run decoded.
                        r_done    <= 1'b1;
                        r_success <= r_best_valid | w_upd;
                        if (!(r_best_valid | w_upd)) begin
                            r_err_vec   <= '0;
                            r_best_wt   <= '0;
                            r_best_cand <= '0;
                        end
                        r_state <= S_FINISH;
                    end else begin
                        r_cand       <= w_cand_next;
                        r_core_bits  <= r_hard ^ w_mask_next;
                        r_core_start <= 1'b1;
                        r_state      <= S_LAUNCH;
                    end
                end
                S_FINISH: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign core_start  = r_core_start;
    assign core_n      = r_core_n;
    assign core_t      = r_core_t;
    assign core_m      = r_core_m;
    assign core_bits   = r_core_bits;
    assign busy        = (r_state != S_IDLE);
    assign done        = r_done;
    assign success     = r_success;
    assign err_vec     = r_err_vec;
    assign best_cand   = r_best_cand;
    assign best_wt     = r_best_wt;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_bch_chase_ctrl.sv
module tb_bch_chase_ctrl;
  localparam int N   = 63;
  localparam int P   = 3;
  localparam int TMO = 16;
  localparam int CORE_LAT = 5;

  logic clk, rst, start;
  logic [9:0] n;
  logic [3:0] t, m;
  logic [1:0] p;
  logic [N-1:0] hard_bits;
  logic [10*P-1:0] lrp_idx;
  logic core_start;
  logic [9:0] core_n;
  logic [3:0] core_t, core_m;
  logic [N-1:0] core_bits;
  logic core_done, core_success;
  logic [N-1:0] core_err_vec;
  logic busy, done, success;
  logic [N-1:0] err_vec;
  logic [P-1:0] best_cand;
  logic [9:0] best_wt;
  logic [2:0] dbg_state;

  bch_chase_ctrl #(.N_MAX(N), .P_MAX(P), .TMO_W(12), .TMO_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .n(n), .t(t), .m(m), .p(p),
    .hard_bits(hard_bits), .lrp_idx(lrp_idx),
    .core_start(core_start), .core_n(core_n), .core_t(core_t), .core_m(core_m),
    .core_bits(core_bits), .core_done(core_done), .core_success(core_success),
    .core_err_vec(core_err_vec), .busy(busy), .done(done), .success(success),
    .err_vec(err_vec), .best_cand(best_cand), .best_wt(best_wt),
    .o_dbg_state(dbg_state)
  );

  // clock / reset block
  int cyc = 0;
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  // scoreboard queues: launch = {n,t,m,bits}, result = {success,err,cand,wt}
  logic [80:0] exp_launch_q[$];
  logic [76:0] exp_res_q[$];
  int          exp_cyc_q[$];

  // core model programming, indexed by launch number within a request
  bit           mdl_succ[8];
  logic [N-1:0] mdl_err[8];
  bit           mdl_hold[8];
  int           mdl_idx = 0;
  bit           stray_req = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // core model: answers CORE_LAT cycles after core_start unless held
  initial begin
    int cnt;
    bit cur_ok, cur_hold;
    logic [N-1:0] cur_err;
    cnt = 0; cur_ok = 0; cur_hold = 0; cur_err = '0;
    core_done = 0; core_success = 0; core_err_vec = '0;
    forever begin
      @(negedge clk);
      core_done = 0; core_success = 0; core_err_vec = '0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0 && !cur_hold) begin
          core_done = 1; core_success = cur_ok; core_err_vec = cur_err;
        end
      end
      if (stray_req) begin
        core_done = 1; core_success = 1; core_err_vec = N'(1);
        stray_req = 0;
      end
      if (core_start) begin
        cnt = CORE_LAT;
        cur_ok = mdl_succ[mdl_idx % 8];
        cur_err = mdl_err[mdl_idx % 8];
        cur_hold = mdl_hold[mdl_idx % 8];
        mdl_idx++;
      end
    end
  end

  // monitor: pops expectations whenever the DUT presents a launch or a result
  initial forever begin
    @(negedge clk);
    if (core_start) begin
      if (exp_launch_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL extra_core_start: got launch bits %0h expected none (cycle %0d)", core_bits, cyc);
      end else begin
        chk("core_launch", {core_n, core_t, core_m, core_bits}, exp_launch_q.pop_front());
      end
    end
    if (done) begin
      done_cnt++;
      if (exp_res_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL extra_done: got done expected none (cycle %0d)", cyc);
      end else begin
        chk("result", {success, err_vec, best_cand, best_wt}, exp_res_q.pop_front());
        chk("done_cycle", 128'(cyc), 128'(exp_cyc_q.pop_front()));
        chk("busy_at_done", 128'(busy), 128'(1));
      end
    end
  end

  task automatic set_tbl(input int c, input bit ok, input logic [N-1:0] e, input bit hold);
    mdl_succ[c] = ok; mdl_err[c] = e; mdl_hold[c] = hold;
  endtask

  function automatic logic [N-1:0] ref_mask(input int c, input int pp, input int nn,
                                            input logic [10*P-1:0] lrp);
    logic [N-1:0] mk;
    int pos;
    mk = '0;
    for (int i = 0; i < pp; i++) begin
      pos = int'(lrp[10*i +: 10]);
      if (((c >> i) & 1) == 1 && pos < nn && pos < N) mk[pos] = ~mk[pos];
    end
    return mk;
  endfunction

  // drives one request; the reference result is derived from the candidate rules
  task automatic run_txn(input logic [9:0] nn, input logic [3:0] tt, input logic [3:0] mm,
                         input logic [1:0] pp, input logic [N-1:0] hw,
                         input logic [10*P-1:0] lrp, input bit start_in_wait,
                         input bit do_abort);
    int lat, bw, bc, w, wc, s, d0;
    bit bv, ok;
    logic [N-1:0] bestv, mk, tot;
    lat = 1; bw = 0; bc = 0; bv = 0; bestv = '0;
    for (int c = 0; c < (1 << pp); c++) begin
      mk = ref_mask(c, int'(pp), int'(nn), lrp);
      if (!do_abort || c == 0) exp_launch_q.push_back({nn, tt, mm, hw ^ mk});
      ok = mdl_hold[c] ? 1'b0 : mdl_succ[c];
      wc = mdl_hold[c] ? TMO : CORE_LAT;
      tot = mdl_err[c] ^ mk;
      w = $countones(tot);
      if (ok && (!bv || w < bw)) begin
        bv = 1; bw = w; bc = c; bestv = tot;
      end
      lat += 2 + wc;
    end
    if (!bv) begin
      bestv = '0; bw = 0; bc = 0;
    end
    mdl_idx = 0;
    d0 = done_cnt;
    @(negedge clk);
    n = nn; t = tt; m = mm; p = pp; hard_bits = hw; lrp_idx = lrp; start = 1;
    s = cyc;
    if (!do_abort) begin
      exp_res_q.push_back({bv, bestv, P'(bc), 10'(bw)});
      exp_cyc_q.push_back(s + lat);
    end
    @(negedge clk);
    start = 0;
    hard_bits = N'({$urandom(), $urandom()});
    lrp_idx = 30'($urandom());
    n = 10'($urandom_range(0, 1023)); p = 2'($urandom_range(0, 3));
    if (start_in_wait) begin
      @(negedge clk);
      start = 1;
      @(negedge clk);
      start = 0;
    end
    if (do_abort) begin
      @(negedge clk);
      @(negedge clk);
      rst = 1;
      @(negedge clk);
      rst = 0;
      chk("rst_busy", 128'(busy), 0);
      chk("rst_core_start", 128'(core_start), 0);
      chk("rst_done", 128'(done), 0);
      chk("rst_outputs", {success, err_vec, best_cand, best_wt}, 0);
      chk("rst_core_if", {core_n, core_t, core_m, core_bits}, 0);
      chk("rst_state", 128'(dbg_state), 0);
      repeat (10) @(negedge clk);
      chk("rst_late_done_ignored", 128'(busy), 0);
    end else begin
      int k;
      k = 0;
      while (done_cnt == d0 && k < 3000) begin
        @(negedge clk);
        k++;
      end
      if (done_cnt == d0) begin
        checks++; errors++;
        $display("FAIL done_timeout: got no done expected done within 3000 cycles");
      end
      @(negedge clk);
    end
  endtask

  // stimulus
  initial begin
    logic [N-1:0] e;
    logic [10*P-1:0] lrp;
    logic [1:0] rp;
    logic [9:0] rn;
    rst = 1; start = 0; n = 0; t = 0; m = 0; p = 0; hard_bits = '0; lrp_idx = '0;
    for (int c = 0; c < 8; c++) set_tbl(c, 0, '0, 0);
    repeat (3) @(negedge clk);
    rst = 0;
    chk("reset_busy", 128'(busy), 0);
    chk("reset_start_done", {core_start, done}, 0);
    chk("reset_outputs", {success, err_vec, best_cand, best_wt}, 0);
    chk("reset_core_if", {core_n, core_t, core_m, core_bits}, 0);

    // p=0, single candidate, one error at bit 3
    set_tbl(0, 1, N'(1) << 3, 0);
    run_txn(10'd63, 4'd2, 4'd6, 2'd0, N'({$urandom(), $urandom()}), '0, 0, 0);
    chk("p0_result", {success, err_vec, best_cand, best_wt}, {1'b1, N'(1) << 3, 3'd0, 10'd1});

    // p=2, flips at 10 and 20
    set_tbl(0, 0, N'(1) << 7, 0);
    set_tbl(1, 1, (N'(1) << 3) | (N'(1) << 40), 0);
    set_tbl(2, 1, '0, 0);
    set_tbl(3, 1, '0, 0);
    run_txn(10'd63, 4'd2, 4'd6, 2'd2, N'({$urandom(), $urandom()}), {10'd0, 10'd20, 10'd10}, 0, 0);
    chk("p2_result", {success, err_vec, best_cand, best_wt}, {1'b1, N'(1) << 20, 3'd2, 10'd1});

    // p=3, every candidate fails
    for (int c = 0; c < 8; c++) set_tbl(c, 0, N'(c + 1), 0);
    run_txn(10'd63, 4'd2, 4'd6, 2'd3, N'({$urandom(), $urandom()}), {10'd1, 10'd2, 10'd3}, 0, 0);
    chk("p3_fail", {success, err_vec, best_cand, best_wt}, 0);

    // candidate 0 withholds core_done and times out
    set_tbl(0, 1, N'(1), 1);
    set_tbl(1, 1, N'(1) << 9, 0);
    run_txn(10'd63, 4'd2, 4'd6, 2'd1, N'({$urandom(), $urandom()}), {20'd0, 10'd5}, 0, 0);
    chk("timeout_result", {success, err_vec, best_cand, best_wt},
        {1'b1, (N'(1) << 9) | (N'(1) << 5), 3'd1, 10'd2});

    // equal weights: lower index wins
    set_tbl(0, 1, N'(1) << 7, 0);
    set_tbl(1, 1, '0, 0);
    run_txn(10'd63, 4'd2, 4'd6, 2'd1, N'({$urandom(), $urandom()}), {20'd0, 10'd5}, 0, 0);
    chk("tie_result", {success, err_vec, best_cand, best_wt}, {1'b1, N'(1) << 7, 3'd0, 10'd1});

    // stray core_done in IDLE, then start during WAIT with an out-of-range flip
    @(negedge clk);
    stray_req = 1;
    repeat (3) @(negedge clk);
    chk("stray_idle_busy", 128'(busy), 0);
    chk("stray_idle_state", 128'(dbg_state), 0);
    set_tbl(0, 1, N'(1) << 1, 0);
    set_tbl(1, 1, '0, 0);
    run_txn(10'd63, 4'd2, 4'd6, 2'd1, N'({$urandom(), $urandom()}), {20'd0, 10'd70}, 1, 0);
    chk("oor_result", {success, err_vec, best_cand, best_wt}, {1'b1, N'(0), 3'd1, 10'd0});

    // reset during WAIT, then a fresh request
    set_tbl(0, 1, N'(1), 0);
    run_txn(10'd63, 4'd2, 4'd6, 2'd2, N'({$urandom(), $urandom()}), {10'd0, 10'd4, 10'd8}, 0, 1);
    set_tbl(0, 0, '0, 0);
    set_tbl(1, 1, N'(1) << 2, 0);
    run_txn(10'd63, 4'd2, 4'd6, 2'd1, N'({$urandom(), $urandom()}), {20'd0, 10'd8}, 0, 0);
    chk("after_rst_result", {success, err_vec, best_cand, best_wt},
        {1'b1, (N'(1) << 2) | (N'(1) << 8), 3'd1, 10'd2});

    // randomized requests
    for (int k = 0; k < 20; k++) begin
      rp = 2'($urandom_range(0, 3));
      rn = 10'($urandom_range(40, 63));
      for (int i = 0; i < P; i++) begin
        lrp[10*i +: 10] = 10'($urandom_range(0, 70));
        if (i > 0 && $urandom_range(0, 3) == 0) lrp[10*i +: 10] = lrp[10*(i-1) +: 10];
      end
      for (int c = 0; c < 8; c++) begin
        e = '0;
        repeat ($urandom_range(0, 3)) e[$urandom_range(0, N - 1)] = 1'b1;
        set_tbl(c, $urandom_range(0, 2) != 0, e, $urandom_range(0, 9) == 0);
      end
      run_txn(rn, 4'($urandom_range(1, 15)), 4'($urandom_range(1, 15)), rp,
              N'({$urandom(), $urandom()}), lrp, $urandom_range(0, 3) == 0, 0);
    end

    repeat (10) @(negedge clk);
    chk("launch_q_drained", 128'(exp_launch_q.size()), 0);
    chk("result_q_drained", 128'(exp_res_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
